// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous word RAM between instruction fetch and data ports.
// Data has fixed priority; fetch gains priority after STARVE_MAX consecutive denials.
module unified_mem_arbiter #(
    parameter int unsigned MEM_AW     = 14,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic [31:0]       d_addr,
    input  logic [3:0]        d_we,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_t;

    owner_t           owner_q;
    owner_t           owner_next;
    logic             rd_q;
    logic             rd_next;
    logic             err_q;
    logic             err_next;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_next;
    logic             i_oor;
    logic             d_oor;
    logic             starved;

    assign i_oor   = |i_addr[31:MEM_AW+2];
    assign d_oor   = |d_addr[31:MEM_AW+2];
    assign starved = (starve_cnt >= CNT_W'(STARVE_MAX));

    // Grant is combinational; held low during reset so every output reads 0.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (Reset_n) begin
            if (d_req && !starved) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // RAM drive in the grant cycle; out-of-range grants never touch the RAM.
    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_we    = 4'b0;
        mem_wdata = 32'd0;
        if (d_gnt) begin
            mem_en    = !d_oor;
            mem_addr  = d_addr[MEM_AW+1:2];
            mem_we    = d_oor ? 4'b0 : d_we;
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_en    = !i_oor;
            mem_addr  = i_addr[MEM_AW+1:2];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            owner_q    <= OWN_NONE;
            rd_q       <= 1'b0;
            err_q      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            owner_q    <= owner_next;
            rd_q       <= rd_next;
            err_q      <= err_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    // Response owner for the next cycle plus the saturating fetch-starvation count.
    always_comb begin
        owner_next      = OWN_NONE;
        rd_next         = 1'b0;
        err_next        = 1'b0;
        starve_cnt_next = starve_cnt;
        if (d_gnt) begin
            owner_next = OWN_D;
            rd_next    = (d_we == 4'b0) && !d_oor;
            err_next   = d_oor;
        end else if (i_gnt) begin
            owner_next = OWN_I;
            rd_next    = !i_oor;
            err_next   = i_oor;
        end
        if (i_gnt) begin
            starve_cnt_next = '0;
        end else if (i_req && !starved) begin
            starve_cnt_next = starve_cnt + CNT_W'(1);
        end
    end

    assign i_rvalid = (owner_q == OWN_I);
    assign i_err    = i_rvalid && err_q;
    assign i_rdata  = (i_rvalid && rd_q) ? mem_rdata : 32'd0;

    assign d_rvalid = (owner_q == OWN_D);
    assign d_err    = d_rvalid && err_q;
    assign d_rdata  = (d_rvalid && rd_q) ? mem_rdata : 32'd0;

    // Byte-offset bits are ignored for word accesses.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: write-first RAM, spec-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_unified_mem_arbiter;
    localparam int unsigned MEM_AW     = 14;
    localparam int unsigned STARVE_MAX = 4;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              i_req, i_gnt, i_rvalid, i_err;
    logic [31:0]       i_addr, i_rdata;
    logic              d_req, d_gnt, d_rvalid, d_err;
    logic [31:0]       d_addr, d_wdata, d_rdata;
    logic [3:0]        d_we;
    logic              mem_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata, mem_rdata;

    unified_mem_arbiter #(.MEM_AW(MEM_AW), .STARVE_MAX(STARVE_MAX)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Write-first single-port RAM
    logic [31:0] ram [0:(1<<MEM_AW)-1];
    always @(posedge Clk) begin
        if (mem_en) begin
            ram[mem_addr] <= merge(ram[mem_addr], mem_we, mem_wdata);
            mem_rdata     <= merge(ram[mem_addr], mem_we, mem_wdata);
        end
    end

    // Reference model state
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cnt = 0;
    int          pend = 0;          // 0 none, 1 fetch, 2 data
    logic [31:0] pend_data = 32'd0;
    logic        pend_err = 1'b0;
    logic [31:0] mm [int];

    function automatic logic [31:0] mm_get(input int w);
        return mm.exists(w) ? mm[w] : 32'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model at the falling edge, then advance the model.
    task automatic sample();
        logic        eg_i, eg_d, oor, rd;
        logic [31:0] ga;
        int          w;
        @(negedge Clk);
        if (!Reset_n) begin
            chk("rst_i_gnt", i_gnt, 0);     chk("rst_d_gnt", d_gnt, 0);
            chk("rst_i_rvalid", i_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_i_err", i_err, 0);     chk("rst_d_err", d_err, 0);
            chk("rst_i_rdata", i_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
            chk("rst_mem_en", mem_en, 0);   chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", 32'(mem_addr), 0); chk("rst_mem_wdata", mem_wdata, 0);
            cnt = 0; pend = 0; pend_data = 0; pend_err = 0;
        end else begin
            eg_i = 1'b0; eg_d = 1'b0;
            if (d_req && cnt < int'(STARVE_MAX)) eg_d = 1'b1;
            else if (i_req) eg_i = 1'b1;
            else if (d_req) eg_d = 1'b1;
            ga  = eg_d ? d_addr : i_addr;
            oor = (ga >> (MEM_AW + 2)) != 32'd0;
            w   = int'((ga >> 2) % (1 << MEM_AW));
            chk("i_gnt", i_gnt, eg_i);
            chk("d_gnt", d_gnt, eg_d);
            chk("mem_en", mem_en, (eg_i || eg_d) && !oor);
            chk("mem_we", mem_we, (eg_d && !oor) ? d_we : 4'b0);
            if ((eg_i || eg_d) && !oor) chk("mem_addr", 32'(mem_addr), 32'(w));
            if (eg_d && !oor && d_we != 4'b0) chk("mem_wdata", mem_wdata, d_wdata);
            chk("i_rvalid", i_rvalid, pend == 1);
            chk("d_rvalid", d_rvalid, pend == 2);
            chk("i_err", i_err, pend == 1 && pend_err);
            chk("d_err", d_err, pend == 2 && pend_err);
            if (pend == 1) chk("i_rdata", i_rdata, pend_data);
            if (pend == 2) chk("d_rdata", d_rdata, pend_data);
            if (eg_d && !oor && d_we != 4'b0) mm[w] = merge(mm_get(w), d_we, d_wdata);
            rd        = eg_i || (eg_d && d_we == 4'b0);
            pend      = eg_d ? 2 : (eg_i ? 1 : 0);
            pend_err  = oor;
            pend_data = (rd && !oor) ? mm_get(w) : 32'd0;
            if (eg_i) cnt = 0;
            else if (i_req && cnt < int'(STARVE_MAX)) cnt = cnt + 1;
        end
    endtask

    task automatic advance();
        @(posedge Clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] v);
        d_req = 1'b1; d_addr = a; d_we = 4'hF; d_wdata = v;
        sample();
        advance();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 15) == 0)
            a = (32'h1 << (16 + $urandom_range(0, 15))) | ($urandom & 32'hFFFF);
        else
            a = ($urandom_range(0, 1) == 1 ? 32'h2000 : 32'h0)
                + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        logic [9:0] pat;
        logic [2:0] pat3;
        logic       ig, dg;

        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_addr = 32'h2000; d_we = 4'h0; d_wdata = 32'h0;
        repeat (3) begin
            sample();
            chk("reset_gnts", {30'd0, i_gnt, d_gnt}, 0);
            advance();
        end
        i_req = 1'b0; d_req = 1'b0;
        Reset_n = 1'b1;

        for (int k = 0; k < 16; k++) store(32'(k * 4), k < 3 ? 32'((k + 1) * 'h11) : $urandom);
        for (int k = 0; k < 16; k++) store(32'h2000 + 32'(k * 4), k == 1 ? 32'h11223344 : $urandom);
        d_req = 1'b0;

        // Fetch-only stream
        i_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_addr = 32'(k * 4);
            sample();
            chk("fetch_gnt", i_gnt, 1);
            if (k > 0) begin
                chk("fetch_rvalid", i_rvalid, 1);
                chk("fetch_rdata", i_rdata, 32'(k * 'h11));
            end
            advance();
        end
        i_req = 1'b0;
        sample();
        chk("fetch_rdata_last", i_rdata, 32'h33);
        chk("fetch_err", i_err, 0);
        advance();

        // Byte store then load-back
        d_req = 1'b1; d_we = 4'b0100; d_addr = 32'h2004; d_wdata = 32'h00AB0000;
        sample(); advance();
        d_we = 4'b0;
        sample();
        chk("bstore_rvalid", d_rvalid, 1);
        chk("bstore_rdata", d_rdata, 0);
        advance();
        d_req = 1'b0;
        sample();
        chk("bload_rdata", d_rdata, 32'h11AB3344);
        advance();

        // Out-of-range store must not touch RAM word 0
        d_req = 1'b1; d_addr = 32'h00010000; d_we = 4'hF; d_wdata = 32'hDEADBEEF;
        sample();
        chk("oor_gnt", d_gnt, 1);
        chk("oor_mem_en", mem_en, 0);
        advance();
        d_addr = 32'h0; d_we = 4'h0;
        sample();
        chk("oor_rvalid", d_rvalid, 1);
        chk("oor_err", d_err, 1);
        chk("oor_rdata", d_rdata, 0);
        advance();
        d_req = 1'b0;
        sample();
        chk("oor_ram_kept", d_rdata, 32'h11);
        chk("oor_err_clear", d_err, 0);
        advance();

        // Reset while a fetch response is outstanding
        i_req = 1'b1; i_addr = 32'h4;
        sample();
        chk("rmid_gnt", i_gnt, 1);
        advance();
        Reset_n = 1'b0;
        sample();
        chk("rmid_rvalid", i_rvalid, 0);
        advance();
        Reset_n = 1'b1; i_addr = 32'h0;
        sample();
        chk("rmid_refetch_gnt", i_gnt, 1);
        advance();
        i_req = 1'b0;
        sample();
        chk("rmid_refetch_rvalid", i_rvalid, 1);
        chk("rmid_refetch_rdata", i_rdata, 32'h11);
        advance();

        // Contention: data wins STARVE_MAX times, then one fetch
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_addr = 32'h2000; d_we = 4'h0;
        for (int c = 0; c < 10; c++) begin
            sample(); pat[c] = i_gnt; advance();
        end
        chk("contention_pattern", 32'(pat), 32'b1000010000);

        // Idle gap holds the starvation count at 2
        repeat (2) begin sample(); advance(); end
        i_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("idle_mem_en", mem_en, 0);
            chk("idle_gnts", {30'd0, i_gnt, d_gnt}, 0);
            if (c > 0) chk("idle_rvalid", {30'd0, i_rvalid, d_rvalid}, 0);
            advance();
        end
        i_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample(); pat3[c] = i_gnt; advance();
        end
        chk("resume_pattern", 32'(pat3), 32'b100);
        i_req = 1'b0; d_req = 1'b0;
        sample(); advance();

        // Randomized traffic; requests are held until granted
        for (int n = 0; n < 3000; n++) begin
            if (!i_req && $urandom_range(0, 3) != 0) begin
                i_req = 1'b1; i_addr = rand_addr();
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1'b1; d_addr = rand_addr();
                d_we = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
                d_wdata = $urandom;
            end
            sample();
            ig = i_gnt; dg = d_gnt;
            advance();
            if (ig) i_req = 1'b0;
            if (dg) d_req = 1'b0;
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) begin sample(); advance(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
